mips_alu: RTL and testbench

//  32-bit integer ALU for the ICOM4215 MIPS-style datapath, in the execute stage.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/mips_alu_if.sv | 32 +++
 rtl/alu_muldiv.sv | 80 ++++++++
 rtl/mips_alu.sv | 112 +++++++++++
 tb/tb_mips_alu.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the MIPS-style execute-stage ALU.
//   OP_*          : 4-bit opcode values on the 'operation' input
//   FLAG_*        : bit positions inside the registered {N,Z,C,V} flag word
//   SIGN_*        : bit positions inside the 2-bit 'sign' control input
package alu_pkg;

    localparam logic [3:0] OP_PASSB  = 4'd0;
    localparam logic [3:0] OP_ADDSUB = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_NOR    = 4'd6;
    localparam logic [3:0] OP_SRL    = 4'd7;
    localparam logic [3:0] OP_SLL    = 4'd8;
    localparam logic [3:0] OP_SRA    = 4'd9;
    localparam logic [3:0] OP_LUI    = 4'd10;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int SIGN_SIGNED = 1;
    localparam int SIGN_SUB    = 0;

endpackage

// File: rtl/mips_alu_if.sv
// mips_alu_if
// Bundles the ALU operand/opcode inputs and registered results.
//   operation  : 4-bit opcode (see alu_pkg OP_*)
//   sign       : [1] signed operands, [0] subtract (add/sub only)
//   A, B       : 32-bit operands; A[4:0] is the shift amount for shifts
//   Y          : registered result
//   outHI      : HI register (product upper word / remainder)
//   outLO      : LO register (product lower word / quotient)
//   carryFlags : registered {N,Z,C,V}
// master = the stage that drives operands, slave = the ALU itself.
interface mips_alu_if;

    logic [3:0]  operation;
    logic [1:0]  sign;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Y;
    logic [31:0] outHI;
    logic [31:0] outLO;
    logic [3:0]  carryFlags;

    modport master (
        output operation, sign, A, B,
        input  Y, outHI, outLO, carryFlags
    );

    modport slave (
        input  operation, sign, A, B,
        output Y, outHI, outLO, carryFlags
    );

endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv
// Purely combinational 32x32 multiply and 32/32 divide, signed or unsigned.
//   a, b     : operands (a = dividend, b = divisor for divide)
//   isSigned : treat operands as two's complement
//   isDiv    : select divide results on hi/lo/ovf instead of multiply
//   hi, lo   : multiply -> product[63:32]/[31:0]; divide -> remainder/quotient
//   ovf      : multiply -> product does not fit in 32 bits;
//              divide   -> signed 0x8000_0000 / -1
//   dz       : divisor is zero
module alu_muldiv (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        isSigned,
    input  logic        isDiv,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        ovf,
    output logic        dz
);

    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] product;
    logic        mulOvf;

    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisor;
    logic [31:0] uQuot;
    logic [31:0] uRem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        divOvf;

    // Extending both operands to 64 bits and keeping the low 64 bits of the
    // product gives the correct result for signed and unsigned alike, so one
    // multiplier serves both.
    assign aExt    = isSigned ? {{32{a[31]}}, a} : {32'd0, a};
    assign bExt    = isSigned ? {{32{b[31]}}, b} : {32'd0, b};
    assign product = aExt * bExt;
    assign mulOvf  = isSigned ? (product[63:32] != {32{product[31]}})
                              : (product[63:32] != 32'd0);

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. The divisor is forced to 1 on a
    // zero divide so the divider never sees zero; those results are replaced.
    assign negA    = isSigned & a[31];
    assign negB    = isSigned & b[31];
    assign magA    = negA ? (~a + 32'd1) : a;
    assign magB    = negB ? (~b + 32'd1) : b;
    assign dz      = (b == 32'd0);
    assign divisor = dz ? 32'd1 : magB;
    assign uQuot   = magA / divisor;
    assign uRem    = magA % divisor;
    assign quot    = (negA ^ negB) ? (~uQuot + 32'd1) : uQuot;
    assign rem     = negA ? (~uRem + 32'd1) : uRem;
    assign divOvf  = isSigned & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);

    // Route either the multiply or divide results out; a zero divide returns
    // an all-ones quotient with the dividend left in the remainder.
    always_comb begin
        hi  = product[63:32];
        lo  = product[31:0];
        ovf = mulOvf;
        if (isDiv) begin
            if (dz) begin
                hi  = a;
                lo  = 32'hFFFF_FFFF;
                ovf = 1'b0;
            end else begin
                hi  = rem;
                lo  = quot;
                ovf = divOvf;
            end
        end
    end

endmodule

// File: rtl/mips_alu.sv
// mips_alu
// 32-bit execute-stage ALU with registered result, NZCV flags and HI/LO pair.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears Y, HI, LO and flags
//   bus   : mips_alu_if.slave carrying operation/sign/A/B in and
//           Y/outHI/outLO/carryFlags out (all outputs one cycle after inputs)
// HI/LO only load on multiply and divide; every other opcode holds them.
module mips_alu (
    input  logic        clk,
    input  logic        reset,
    mips_alu_if.slave   bus
);

    import alu_pkg::*;

    logic        isSigned;
    logic        isSub;
    logic [31:0] bOperand;
    logic [32:0] sum33;

    logic [31:0] mdHi;
    logic [31:0] mdLo;
    logic        mdOvf;
    logic        mdDz;

    logic [31:0] yNext;
    logic        carryNext;
    logic        ovfNext;
    logic        loadHiLo;
    logic [3:0]  flagsNext;

    assign isSigned = bus.sign[SIGN_SIGNED];
    assign isSub    = bus.sign[SIGN_SUB];

    // Subtraction is A + ~B + 1, so C reads as "no borrow" when subtracting.
    assign bOperand = isSub ? ~bus.B : bus.B;
    assign sum33    = {1'b0, bus.A} + {1'b0, bOperand} + {32'd0, isSub};

    alu_muldiv u_muldiv (
        .a        (bus.A),
        .b        (bus.B),
        .isSigned (isSigned),
        .isDiv    (bus.operation == OP_DIV),
        .hi       (mdHi),
        .lo       (mdLo),
        .ovf      (mdOvf),
        .dz       (mdDz)
    );

    // Result mux; unused opcodes 11-15 fall to a zero result with C=V=0.
    always_comb begin
        yNext     = 32'd0;
        carryNext = 1'b0;
        ovfNext   = 1'b0;
        loadHiLo  = 1'b0;
        case (bus.operation)
            OP_PASSB:  yNext = bus.B;
            OP_ADDSUB: begin
                yNext     = sum33[31:0];
                carryNext = sum33[32];
                ovfNext   = isSigned & (bus.A[31] == bOperand[31])
                                     & (sum33[31] != bus.A[31]);
            end
            OP_MUL: begin
                yNext    = mdLo;
                ovfNext  = mdOvf;
                loadHiLo = 1'b1;
            end
            OP_DIV: begin
                yNext    = mdLo;
                ovfNext  = mdOvf | mdDz;
                loadHiLo = 1'b1;
            end
            OP_AND:    yNext = bus.A & bus.B;
            OP_OR:     yNext = bus.A | bus.B;
            OP_NOR:    yNext = ~(bus.A | bus.B);
            OP_SRL:    yNext = bus.B >> bus.A[4:0];
            OP_SLL:    yNext = bus.B << bus.A[4:0];
            OP_SRA:    yNext = $signed(bus.B) >>> bus.A[4:0];
            OP_LUI:    yNext = {bus.B[15:0], 16'h0000};
            default:   yNext = 32'd0;
        endcase
    end

    // N and Z come straight from the next result for every opcode.
    always_comb begin
        flagsNext         = 4'b0000;
        flagsNext[FLAG_N] = yNext[31];
        flagsNext[FLAG_Z] = (yNext == 32'd0);
        flagsNext[FLAG_C] = carryNext;
        flagsNext[FLAG_V] = ovfNext;
    end

    // Output registers; reset wins over everything, and the first edge after
    // release simply computes from whatever inputs are present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.Y          <= 32'd0;
            bus.outHI      <= 32'd0;
            bus.outLO      <= 32'd0;
            bus.carryFlags <= 4'b0000;
        end else begin
            bus.Y          <= yNext;
            bus.carryFlags <= flagsNext;
            if (loadHiLo) begin
                bus.outHI <= mdHi;
                bus.outLO <= mdLo;
            end
        end
    end

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu
// Drives mips_alu through its interface. Each vector's expected Y/HI/LO/flags
// are pushed onto a scoreboard queue when driven and popped one edge later.
module tb_mips_alu;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [3:0]  f;
        string       name;
    } vec_t;

    typedef struct {
        logic [99:0] bits;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [31:0] holdHi      = 32'd0;
    logic [31:0] holdLo      = 32'd0;
    exp_t        sbQ[$];

    always #5 clk = ~clk;

    mips_alu_if bus ();

    mips_alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic vec_t mkVec(input logic [3:0] op, input logic [1:0] sg,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] y, input logic [31:0] hi,
                                   input logic [31:0] lo, input logic [3:0] f,
                                   input string name);
        vec_t t;
        t.op = op; t.sg = sg; t.a = a; t.b = b;
        t.y = y; t.hi = hi; t.lo = lo; t.f = f; t.name = name;
        return t;
    endfunction

    // Drive one vector on the falling edge and record what should appear
    // after the next rising edge; HI/LO expectations follow the hold rule.
    task automatic applyStimulus(input vec_t t);
        exp_t e;
        @(negedge clk);
        bus.operation = t.op;
        bus.sign      = t.sg;
        bus.A         = t.a;
        bus.B         = t.b;
        if (t.op == 4'd2 || t.op == 4'd3) begin
            holdHi = t.hi;
            holdLo = t.lo;
        end
        e.bits = {t.y, holdHi, holdLo, t.f};
        e.name = t.name;
        sbQ.push_back(e);
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [99:0] got;
        reset         = 1'b1;
        bus.operation = 4'd1;
        bus.sign      = 2'b00;
        bus.A         = 32'd5;
        bus.B         = 32'd3;
        #3;
        e.bits = 100'd0; e.name = "reset_state"; sbQ.push_back(e);
        e = sbQ.pop_front();
        got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
        vectorCount++;
        if (got !== e.bits) begin
            missCount++;
            $display("[TB] FAIL %s: got %h want %h", e.name, got, e.bits);
        end
        @(negedge clk);
        reset = 1'b0;
        e.bits = {32'd8, 32'd0, 32'd0, 4'b0000}; e.name = "first_after_release";
        sbQ.push_back(e);
        @(posedge clk); #1;
        e = sbQ.pop_front();
        got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
        vectorCount++;
        if (got !== e.bits) begin
            missCount++;
            $display("[TB] FAIL %s: got %h want %h", e.name, got, e.bits);
        end
        @(negedge clk);
        bus.operation = 4'd2;
        bus.A         = 32'd3;
        bus.B         = 32'd4;
        #2 reset = 1'b1;
        #1;
        e.bits = 100'd0; e.name = "reset_mid_op"; sbQ.push_back(e);
        e = sbQ.pop_front();
        got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
        vectorCount++;
        if (got !== e.bits) begin
            missCount++;
            $display("[TB] FAIL %s: got %h want %h", e.name, got, e.bits);
        end
        #1 reset = 1'b0;
        holdHi = 32'd0;
        holdLo = 32'd12;
        e.bits = {32'd12, holdHi, holdLo, 4'b0000}; e.name = "mul_after_mid_reset";
        sbQ.push_back(e);
        @(posedge clk); #1;
        e = sbQ.pop_front();
        got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
        vectorCount++;
        if (got !== e.bits) begin
            missCount++;
            $display("[TB] FAIL %s: got %h want %h", e.name, got, e.bits);
        end
    endtask

    task automatic test_addsub();
        vec_t        v[$];
        exp_t        e;
        logic [99:0] got;
        logic [31:0] a, b, y;
        logic        c, sub;
        v.push_back(mkVec(4'd1, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'd4, 0, 0, 4'b0010, "sub_signed"));
        v.push_back(mkVec(4'd1, 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 4'b1001, "sub_signed_ovf"));
        v.push_back(mkVec(4'd1, 2'b01, 32'd5, 32'd5, 32'd0, 0, 0, 4'b0110, "sub_equal"));
        v.push_back(mkVec(4'd1, 2'b00, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 4'b1000, "add_unsigned_no_v"));
        v.push_back(mkVec(4'd1, 2'b10, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 0, 4'b1001, "add_signed_ovf"));
        v.push_back(mkVec(4'd1, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 4'b0110, "add_carry_zero"));
        for (int i = 0; i < 6; i++) begin
            a   = $urandom;
            b   = $urandom;
            sub = i[0];
            if (sub) begin
                y = a - b;
                c = (a >= b);
            end else begin
                {c, y} = {1'b0, a} + {1'b0, b};
            end
            v.push_back(mkVec(4'd1, {1'b0, sub}, a, b, y, 0, 0,
                              {y[31], (y == 32'd0), c, 1'b0}, sub ? "rand_sub" : "rand_add"));
        end
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(posedge clk); #1;
            e = sbQ.pop_front();
            got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
            vectorCount++;
            if (got !== e.bits) begin
                missCount++;
                $display("[TB] FAIL %s: got Y=%h HI=%h LO=%h NZCV=%b want Y=%h HI=%h LO=%h NZCV=%b",
                         e.name, got[99:68], got[67:36], got[35:4], got[3:0],
                         e.bits[99:68], e.bits[67:36], e.bits[35:4], e.bits[3:0]);
            end
        end
    endtask

    task automatic test_muldiv();
        vec_t        v[$];
        exp_t        e;
        logic [99:0] got;
        logic [31:0] a, b;
        logic [63:0] p;
        v.push_back(mkVec(4'd2, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'd32, 32'd0, 32'd32, 4'b0000, "mul_signed"));
        v.push_back(mkVec(4'd4, 2'b10, 32'hFFFF_FFFA, 32'd7, 32'd2, 0, 0, 4'b0000, "and_holds_hilo"));
        v.push_back(mkVec(4'd3, 2'b10, 32'd32, 32'hFFFF_FFF6, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFD, 4'b1000, "div_signed"));
        v.push_back(mkVec(4'd3, 2'b10, 32'd32, 32'd0, 32'hFFFF_FFFF, 32'd32, 32'hFFFF_FFFF, 4'b1001, "div_by_zero"));
        v.push_back(mkVec(4'd3, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'h8000_0000, 4'b1001, "div_min_by_m1"));
        v.push_back(mkVec(4'd3, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b1000, "div_neg_rem"));
        v.push_back(mkVec(4'd3, 2'b00, 32'hFFFF_FFF6, 32'd3, 32'h5555_5552, 32'd0, 32'h5555_5552, 4'b0000, "div_unsigned"));
        v.push_back(mkVec(4'd2, 2'b10, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 32'd0, 4'b0101, "mul_signed_ovf"));
        v.push_back(mkVec(4'd2, 2'b10, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 4'b1000, "mul_signed_fits"));
        v.push_back(mkVec(4'd2, 2'b00, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'd4, 32'hFFFF_FFFB, 4'b1001, "mul_unsigned_ovf"));
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i < 2) ? 32'($urandom_range(0, 65535)) : $urandom;
            p = {32'd0, a} * {32'd0, b};
            v.push_back(mkVec(4'd2, 2'b00, a, b, p[31:0], p[63:32], p[31:0],
                              {p[31], (p[31:0] == 32'd0), 1'b0, (p[63:32] != 32'd0)}, "rand_mul"));
        end
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(posedge clk); #1;
            e = sbQ.pop_front();
            got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
            vectorCount++;
            if (got !== e.bits) begin
                missCount++;
                $display("[TB] FAIL %s: got Y=%h HI=%h LO=%h NZCV=%b want Y=%h HI=%h LO=%h NZCV=%b",
                         e.name, got[99:68], got[67:36], got[35:4], got[3:0],
                         e.bits[99:68], e.bits[67:36], e.bits[35:4], e.bits[3:0]);
            end
        end
    endtask

    task automatic test_logic();
        vec_t        v[$];
        exp_t        e;
        logic [99:0] got;
        v.push_back(mkVec(4'd4, 2'b00, 32'hFFFF_FFFA, 32'd7, 32'd2, 0, 0, 4'b0000, "and"));
        v.push_back(mkVec(4'd5, 2'b11, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0, 0, 4'b0000, "or"));
        v.push_back(mkVec(4'd6, 2'b00, 32'd4, 32'd8, 32'hFFFF_FFF3, 0, 0, 4'b1000, "nor"));
        v.push_back(mkVec(4'd0, 2'b00, 32'd5, 32'd8, 32'd8, 0, 0, 4'b0000, "passb"));
        v.push_back(mkVec(4'd0, 2'b11, 32'd5, 32'd0, 32'd0, 0, 0, 4'b0100, "passb_zero"));
        v.push_back(mkVec(4'd10, 2'b00, 32'd0, 32'd8, 32'h0008_0000, 0, 0, 4'b0000, "lui"));
        v.push_back(mkVec(4'd10, 2'b00, 32'd0, 32'hFFFF_8001, 32'h8001_0000, 0, 0, 4'b1000, "lui_neg"));
        v.push_back(mkVec(4'd15, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 4'b0100, "op15"));
        v.push_back(mkVec(4'd11, 2'b01, 32'h1234_5678, 32'h8765_4321, 32'd0, 0, 0, 4'b0100, "op11"));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(posedge clk); #1;
            e = sbQ.pop_front();
            got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
            vectorCount++;
            if (got !== e.bits) begin
                missCount++;
                $display("[TB] FAIL %s: got Y=%h HI=%h LO=%h NZCV=%b want Y=%h HI=%h LO=%h NZCV=%b",
                         e.name, got[99:68], got[67:36], got[35:4], got[3:0],
                         e.bits[99:68], e.bits[67:36], e.bits[35:4], e.bits[3:0]);
            end
        end
    endtask

    task automatic test_shift();
        vec_t        v[$];
        exp_t        e;
        logic [99:0] got;
        logic [31:0] b, y;
        int          s;
        v.push_back(mkVec(4'd7, 2'b00, 32'd1, 32'h8000_0008, 32'h4000_0004, 0, 0, 4'b0000, "srl"));
        v.push_back(mkVec(4'd8, 2'b00, 32'd1, 32'h8000_0008, 32'h0000_0010, 0, 0, 4'b0000, "sll"));
        v.push_back(mkVec(4'd9, 2'b00, 32'd1, 32'h8000_0008, 32'hC000_0004, 0, 0, 4'b1000, "sra"));
        v.push_back(mkVec(4'd7, 2'b00, 32'h0000_0021, 32'h8000_0008, 32'h4000_0004, 0, 0, 4'b0000, "srl_amt_5bit"));
        v.push_back(mkVec(4'd8, 2'b00, 32'd31, 32'd1, 32'h8000_0000, 0, 0, 4'b1000, "sll_31"));
        v.push_back(mkVec(4'd9, 2'b10, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 4'b1000, "sra_31"));
        v.push_back(mkVec(4'd8, 2'b00, 32'd1, 32'h8000_0000, 32'd0, 0, 0, 4'b0100, "sll_out"));
        for (int i = 0; i < 3; i++) begin
            b = $urandom;
            s = $urandom_range(0, 31);
            y = b;
            for (int k = 0; k < s; k++) y = {y[31], y[31:1]};
            v.push_back(mkVec(4'd9, 2'b00, 32'(s), b, y, 0, 0,
                              {y[31], (y == 32'd0), 2'b00}, "rand_sra"));
        end
        foreach (v[i]) begin
            applyStimulus(v[i]);
            @(posedge clk); #1;
            e = sbQ.pop_front();
            got = {bus.Y, bus.outHI, bus.outLO, bus.carryFlags};
            vectorCount++;
            if (got !== e.bits) begin
                missCount++;
                $display("[TB] FAIL %s: got Y=%h HI=%h LO=%h NZCV=%b want Y=%h HI=%h LO=%h NZCV=%b",
                         e.name, got[99:68], got[67:36], got[35:4], got[3:0],
                         e.bits[99:68], e.bits[67:36], e.bits[35:4], e.bits[3:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_addsub();
        test_muldiv();
        test_logic();
        test_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
